fpu_sgnj_stage: RTL

//  Pipelined FPU execution stage for the sign-injection group (FSGNJ.S, FSGNJN.S, FSGNJX.S).

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_pipe_reg.sv | 33 +++
 rtl/fpu_sgnj_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sign-injection op encoding and the bit-level result helper
// used by the sign-injection stage and any other unit that needs the same result.
package fpu_pkg;

   typedef enum logic [1:0] {
      SGNJ_J   = 2'b00,
      SGNJ_N   = 2'b01,
      SGNJ_X   = 2'b10,
      SGNJ_RSV = 2'b11
   } sgnj_op_t;

   localparam int FP_W        = 32;
   localparam int FP_SIGN_BIT = 31;

   // Reserved op passes x1 through untouched; the caller flags it as illegal.
   function automatic logic [FP_W-1:0] sgnj_result(input sgnj_op_t op,
                                                    input logic [FP_W-1:0] x1,
                                                    input logic [FP_W-1:0] x2);
      logic sgn;
      sgn = x1[FP_SIGN_BIT];
      case (op)
         SGNJ_J:  sgn = x2[FP_SIGN_BIT];
         SGNJ_N:  sgn = ~x2[FP_SIGN_BIT];
         SGNJ_X:  sgn = x1[FP_SIGN_BIT] ^ x2[FP_SIGN_BIT];
         default: sgn = x1[FP_SIGN_BIT];
      endcase
      return {sgn, x1[FP_SIGN_BIT-1:0]};
   endfunction

   function automatic logic sgnj_illegal(input sgnj_op_t op);
      return (op == SGNJ_RSV);
   endfunction

endpackage

// File: rtl/fpu_pipe_reg.sv
// One valid/ready register slice. Holds its payload stable while stalled;
// flush drops the valid bit but leaves the payload, reset clears both.
module fpu_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/fpu_sgnj_stage.sv
// Two-stage sign-injection execution unit (FSGNJ/FSGNJN/FSGNJX) with tag carry,
// backpressure, flush and a completed-op counter.
module fpu_sgnj_stage
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_x1,
   input  logic [31:0]      in_x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [CNT_W-1:0] op_count
);

   localparam int S1_W = 2 + 2*FP_W + TAG_W;
   localparam int S2_W = 1 + FP_W + TAG_W;

   logic             s1_ready;
   logic             s1_v;
   logic [S1_W-1:0]  s1_data;
   logic             s2_ready;
   logic [S2_W-1:0]  s2_in;
   logic [S2_W-1:0]  s2_data;

   logic [1:0]       s1_op;
   logic [31:0]      s1_x1;
   logic [31:0]      s1_x2;
   logic [TAG_W-1:0] s1_tag;

   fpu_pipe_reg #(.W(S1_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (s1_ready),
      .in_data   ({in_op, in_x1, in_x2, in_tag}),
      .out_valid (s1_v),
      .out_ready (s2_ready),
      .out_data  (s1_data)
   );

   assign {s1_op, s1_x1, s1_x2, s1_tag} = s1_data;

   assign s2_in = {sgnj_illegal(sgnj_op_t'(s1_op)),
                   sgnj_result(sgnj_op_t'(s1_op), s1_x1, s1_x2),
                   s1_tag};

   fpu_pipe_reg #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (s1_v),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign {out_illegal, out_y, out_tag} = s2_data;

   // Held low during reset so upstream never sees a handshake that reset would discard.
   assign in_ready = s1_ready && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (out_valid && out_ready && !flush) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule
